// File: rtl/fp_exec_sequencer_if.sv
// Execute-stage FP sequencing bus: pipeline control in, alu_fp result in,
// start/stall/select and captured result out.
interface fp_exec_sequencer_if #(
  parameter int N = 24
);
  // Pipeline control and alu_fp outputs seen by the sequencer
  logic         ValidE;
  logic         ALUSelE;
  logic         FlushE;
  logic         StallExtE;
  logic [N-1:0] FPResult;
  logic [3:0]   FPFlags;
  // Sequencer outputs
  logic         FPStart;
  logic         StallFP;
  logic         ALUSelOut;
  logic [N-1:0] FPResultH;
  logic [3:0]   FPFlagsH;
  logic         FPBusy;

  // Sequencer side
  modport master (
    input  ValidE, ALUSelE, FlushE, StallExtE, FPResult, FPFlags,
    output FPStart, StallFP, ALUSelOut, FPResultH, FPFlagsH, FPBusy
  );

  // Pipeline / alu_fp side
  modport slave (
    output ValidE, ALUSelE, FlushE, StallExtE, FPResult, FPFlags,
    input  FPStart, StallFP, ALUSelOut, FPResultH, FPFlagsH, FPBusy
  );
endinterface

// File: rtl/fp_exec_sequencer.sv
// Sequences the multi-cycle alu_fp in the execute stage: start pulse,
// latency countdown, F/D/E stall, result/flag capture and result-mux select.
module fp_exec_sequencer #(
  parameter int N      = 24,
  parameter int FP_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_exec_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [N-1:0]       result_reg;
  logic [3:0]         flags_reg;

  // A real, unflushed FP instruction sitting in E while we are idle
  logic start_req;
  assign start_req = bus.ValidE & bus.ALUSelE & ~bus.FlushE;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; DONE never restarts, the next FP op issues from IDLE
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (start_req) state_next = RUN;
      RUN: begin
        if (bus.FlushE)             state_next = IDLE;
        else if (cnt_reg == '0)     state_next = DONE;
      end
      DONE: begin
        if (bus.FlushE || !bus.StallExtE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs; StallExtE only matters in DONE, where the held result waits for M
  always_comb begin
    bus.FPStart   = 1'b0;
    bus.StallFP   = 1'b0;
    bus.ALUSelOut = 1'b0;
    unique case (state_reg)
      IDLE: begin
        bus.FPStart = start_req;
        bus.StallFP = start_req;
      end
      RUN: begin
        bus.StallFP = 1'b1;
      end
      DONE: begin
        bus.ALUSelOut = 1'b1;
        bus.StallFP   = bus.StallExtE;
      end
      default: ;
    endcase
  end

  assign bus.FPBusy = (state_reg != IDLE);

  // Latency counter: loaded on start so that capture lands FP_LAT-1 cycles later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (state_reg == IDLE && start_req) begin
      cnt_reg <= CNT_W'(FP_LAT - 2);
    end else if (state_reg == RUN && !bus.FlushE && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // Result/flag capture; held untouched outside the capture cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_reg <= '0;
      flags_reg  <= '0;
    end else if (state_reg == RUN && !bus.FlushE && cnt_reg == '0) begin
      result_reg <= bus.FPResult;
      flags_reg  <= bus.FPFlags;
    end
  end

  assign bus.FPResultH = result_reg;
  assign bus.FPFlagsH  = flags_reg;

endmodule

// File: tb/tb_fp_exec_sequencer.sv
// Bench for fp_exec_sequencer: cycle-phase model compared every cycle plus
// literal timing/value expectations for each directed scenario.
module tb_fp_exec_sequencer;
  localparam int N      = 24;
  localparam int FP_LAT = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_exec_sequencer_if #(.N(N)) bus ();

  fp_exec_sequencer #(.N(N), .FP_LAT(FP_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: phase = cycles since the start cycle (start cycle is phase 0, idle)
  bit           m_active, a_nx;
  int           m_p, p_nx;
  logic [N-1:0] m_res, r_nx;
  logic [3:0]   m_flags, f_nx;

  // Value the fake alu_fp delivers for the op currently in flight
  logic [N-1:0] op_val   = '0;
  logic [3:0]   op_flags = '0;

  // Monitors
  int start_log[$];
  int stall_cnt = 0;
  int sel_cnt   = 0;
  int sel_first = 0;

  // Fake alu_fp: result valid only in the cycle FP_LAT-1 after start
  always_comb begin
    if (m_active && m_p == FP_LAT - 1) begin
      bus.FPResult = op_val;
      bus.FPFlags  = op_flags;
    end else begin
      bus.FPResult = ~op_val;
      bus.FPFlags  = ~op_flags;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then model advance
  always @(negedge clk) begin : cmp
    logic go, e_start, e_stall, e_sel, e_busy;
    logic [N-1:0] e_res;
    logic [3:0]   e_flags;
    cyc++;
    go   = bus.ValidE & bus.ALUSelE & ~bus.FlushE;
    a_nx = m_active; p_nx = m_p; r_nx = m_res; f_nx = m_flags;
    e_res = m_res; e_flags = m_flags;
    if (!rst) begin
      e_start = 0; e_stall = 0; e_sel = 0; e_busy = 0;
      e_res = '0; e_flags = '0;
      a_nx = 0; p_nx = 0; r_nx = '0; f_nx = '0;
    end else if (!m_active) begin
      e_start = go; e_stall = go; e_sel = 0; e_busy = 0;
      if (go) begin a_nx = 1; p_nx = 1; end
    end else if (m_p < FP_LAT) begin
      e_start = 0; e_stall = 1; e_sel = 0; e_busy = 1;
      if (bus.FlushE) a_nx = 0;
      else begin
        if (m_p == FP_LAT - 1) begin r_nx = op_val; f_nx = op_flags; end
        p_nx = m_p + 1;
      end
    end else begin
      e_start = 0; e_stall = bus.StallExtE; e_sel = 1; e_busy = 1;
      if (bus.FlushE || !bus.StallExtE) a_nx = 0;
    end
    chk("FPStart",   32'(bus.FPStart),   32'(e_start));
    chk("StallFP",   32'(bus.StallFP),   32'(e_stall));
    chk("ALUSelOut", 32'(bus.ALUSelOut), 32'(e_sel));
    chk("FPBusy",    32'(bus.FPBusy),    32'(e_busy));
    chk("FPResultH", 32'(bus.FPResultH), 32'(e_res));
    chk("FPFlagsH",  32'(bus.FPFlagsH),  32'(e_flags));
    if (rst) begin
      if (bus.FPStart) start_log.push_back(cyc);
      if (bus.StallFP) stall_cnt++;
      if (bus.ALUSelOut) begin
        if (sel_cnt == 0) sel_first = cyc;
        sel_cnt++;
      end
    end
  end

  // Commit model state after the DUT has sampled this edge
  always @(posedge clk) begin
    m_active <= a_nx;
    m_p      <= p_nx;
    m_res    <= r_nx;
    m_flags  <= f_nx;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    start_log.delete();
    stall_cnt = 0;
    sel_cnt   = 0;
    sel_first = 0;
  endtask

  initial begin
    m_active = 0; m_p = 0; m_res = '0; m_flags = '0;
    a_nx = 0; p_nx = 0; r_nx = '0; f_nx = '0;
    bus.ValidE = 0; bus.ALUSelE = 0; bus.FlushE = 0; bus.StallExtE = 0;

    // Reset state
    #2;
    chk("rst_FPStart",   32'(bus.FPStart),   0);
    chk("rst_StallFP",   32'(bus.StallFP),   0);
    chk("rst_FPResultH", 32'(bus.FPResultH), 0);
    step(3);
    rst = 1;
    step(2);

    // Single FP op, result 3F8000 at t+3
    clear_mon();
    op_val = 24'h3F8000; op_flags = 4'h8;
    bus.ValidE = 1; bus.ALUSelE = 1;
    step(FP_LAT + 1);
    bus.ValidE = 0; bus.ALUSelE = 0;
    step(2);
    chk("t2_starts",     32'(start_log.size()), 1);
    chk("t2_stall_cnt",  32'(stall_cnt), FP_LAT);
    chk("t2_sel_cnt",    32'(sel_cnt), 1);
    if (start_log.size() > 0)
      chk("t2_sel_offset", 32'(sel_first - start_log[0]), FP_LAT);
    chk("t2_result",     32'(bus.FPResultH), 32'h3F8000);
    chk("t2_flags",      32'(bus.FPFlagsH),  32'h8);
    $display("txn single_fp: result %h flags %h", bus.FPResultH, bus.FPFlagsH);

    // Scalar op stream
    clear_mon();
    bus.ValidE = 1; bus.ALUSelE = 0;
    step(20);
    bus.ValidE = 0;
    step(1);
    chk("t3_starts", 32'(start_log.size()), 0);
    chk("t3_stall",  32'(stall_cnt), 0);
    chk("t3_sel",    32'(sel_cnt), 0);
    $display("txn scalar_stream: 20 cycles, stalls %0d", stall_cnt);

    // Flush in RUN at t+2
    clear_mon();
    op_val = 24'h123456; op_flags = 4'h3;
    bus.ValidE = 1; bus.ALUSelE = 1;
    step(2);
    bus.FlushE = 1;
    step(1);
    bus.FlushE = 0; bus.ValidE = 0; bus.ALUSelE = 0;
    chk("t4_stall_t3", 32'(bus.StallFP), 0);
    chk("t4_busy_t3",  32'(bus.FPBusy),  0);
    step(6);
    chk("t4_result", 32'(bus.FPResultH), 32'h3F8000);
    chk("t4_sel",    32'(sel_cnt), 0);
    $display("txn flush_run: result held %h", bus.FPResultH);

    // StallExtE for 3 cycles in DONE
    clear_mon();
    op_val = 24'hABCDEF; op_flags = 4'h5;
    bus.ValidE = 1; bus.ALUSelE = 1;
    step(FP_LAT);
    bus.StallExtE = 1;
    step(3);
    chk("t5_result_held", 32'(bus.FPResultH), 32'hABCDEF);
    bus.StallExtE = 0;
    step(1);
    bus.ValidE = 0; bus.ALUSelE = 0;
    step(2);
    chk("t5_starts",    32'(start_log.size()), 1);
    chk("t5_sel_cnt",   32'(sel_cnt), 4);
    chk("t5_stall_cnt", 32'(stall_cnt), FP_LAT + 3);
    chk("t5_result",    32'(bus.FPResultH), 32'hABCDEF);
    $display("txn done_stall: sel %0d stall %0d", sel_cnt, stall_cnt);

    // Back-to-back FP ops
    clear_mon();
    op_val = 24'h400000; op_flags = 4'h2;
    bus.ValidE = 1; bus.ALUSelE = 1;
    step(FP_LAT);
    chk("t6_result1", 32'(bus.FPResultH), 32'h400000);
    chk("t6_flags1",  32'(bus.FPFlagsH),  32'h2);
    op_val = 24'hC0A000; op_flags = 4'h9;
    step(1 + FP_LAT);
    step(1);
    bus.ValidE = 0; bus.ALUSelE = 0;
    step(2);
    chk("t6_starts", 32'(start_log.size()), 2);
    if (start_log.size() == 2)
      chk("t6_spacing", 32'(start_log[1] - start_log[0]), FP_LAT + 1);
    chk("t6_result2", 32'(bus.FPResultH), 32'hC0A000);
    chk("t6_flags2",  32'(bus.FPFlagsH),  32'h9);
    $display("txn back_to_back: result2 %h", bus.FPResultH);

    // Reset mid-RUN at t+2
    clear_mon();
    op_val = 24'h777777; op_flags = 4'hF;
    bus.ValidE = 1; bus.ALUSelE = 1;
    step(2);
    rst = 0; bus.ValidE = 0; bus.ALUSelE = 0;
    #1;
    chk("t1_start",  32'(bus.FPStart),   0);
    chk("t1_stall",  32'(bus.StallFP),   0);
    chk("t1_sel",    32'(bus.ALUSelOut), 0);
    chk("t1_busy",   32'(bus.FPBusy),    0);
    chk("t1_result", 32'(bus.FPResultH), 0);
    chk("t1_flags",  32'(bus.FPFlagsH),  0);
    step(2);
    rst = 1;
    clear_mon();
    step(5);
    chk("t1_no_start", 32'(start_log.size()), 0);
    $display("txn reset_mid_run: result %h", bus.FPResultH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
